// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake, applies redirects.
// Latency: fetched word presented to D the cycle after ack; at most one instruction per 2 cycles.
// Backpressure: stall_i holds the presented slot; imem_req_o held with stable address until ack.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        npc_sel_i,
    input  logic [31:0] npc_i,
    input  logic        jr_sel_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic        adel_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] tgt_q,        tgt_d;
    logic [31:0] disc_addr_q,  disc_addr_d;
    logic        valid_q,      valid_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] ipc_q,        ipc_d;
    logic        adel_q,       adel_d;

    logic        pc_fault;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc_plus4;

    // Decode of the current PC legality and of the redirect sources seen this cycle.
    always_comb begin
        pc_fault  = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
        redir     = !stall_i && (npc_sel_i || jr_sel_i);
        redir_tgt = jr_sel_i ? jr_target_i : npc_i;
        flush     = exc_i || eret_i;
        flush_pc  = exc_i ? EXC_VECTOR : epc_i;
        pc_plus4  = pc_q + 32'd4;
    end

    // Memory-side outputs: a faulting PC never reaches the bus; a discarded fetch
    // keeps its original address on the bus until the memory answers it.
    always_comb begin
        imem_req_o  = ((state_q == S_REQ) && !pc_fault) || (state_q == S_DISCARD);
        imem_addr_o = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    end

    // D-stage outputs come straight from the slot registers.
    always_comb begin
        if_valid_o = valid_q;
        if_instr_o = instr_q;
        if_pc_o    = ipc_q;
        if_pc4_o   = ipc_q + 32'd4;
        adel_o     = adel_q;
    end

    // Next-state and slot update; exception/eret overrides everything, including branch redirects.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        tgt_d        = tgt_q;
        disc_addr_d  = disc_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
        adel_d       = adel_q;

        if (flush) begin
            pc_d         = flush_pc;
            redir_pend_d = 1'b0;
            valid_d      = 1'b0;
            adel_d       = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // A live request without its ack must be drained before refetching.
                    if (!pc_fault && !imem_ack_i) begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DISCARD: state_d = imem_ack_i ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                    if (redir) begin
                        redir_pend_d = 1'b1;
                        tgt_d        = redir_tgt;
                    end
                end
                S_REQ: begin
                    // The fetch in flight is the delay slot: a redirect only arms the target.
                    if (redir) begin
                        redir_pend_d = 1'b1;
                        tgt_d        = redir_tgt;
                    end
                    if (pc_fault) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        instr_d = 32'h0000_0000;
                        ipc_d   = pc_q;
                        adel_d  = 1'b1;
                    end else if (imem_ack_i) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        instr_d = imem_rdata_i;
                        ipc_d   = pc_q;
                        adel_d  = 1'b0;
                    end
                end
                S_HOLD: begin
                    // Consumption; a redirect arriving now bypasses the pending register.
                    if (!stall_i) begin
                        if (redir) begin
                            pc_d = redir_tgt;
                        end else if (redir_pend_q) begin
                            pc_d = tgt_q;
                        end else begin
                            pc_d = pc_plus4;
                        end
                        redir_pend_d = 1'b0;
                        valid_d      = 1'b0;
                        adel_d       = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (redir) begin
                        redir_pend_d = 1'b1;
                        tgt_d        = redir_tgt;
                    end
                    if (imem_ack_i) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and slot registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            tgt_q        <= 32'h0000_0000;
            disc_addr_q  <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            ipc_q        <= RESET_PC;
            adel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            tgt_q        <= tgt_d;
            disc_addr_q  <= disc_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            adel_q       <= adel_d;
        end
    end

endmodule
